// File: rtl/index_decoder_pkg.sv
// Shared helpers for the index decoder: width functions and a popcount.
// Imported by index_decoder and onehot_decode.
package index_pkg;

    function automatic int idx_width(input int width);
        return (width > 1) ? $clog2(width) : 1;
    endfunction

    function automatic int cnt_width(input int width);
        return $clog2(width + 1);
    endfunction

    function automatic int unsigned popcount(input logic [63:0] v);
        int unsigned n;
        n = 0;
        for (int i = 0; i < 64; i++) begin
            n += {31'd0, v[i]};
        end
        return n;
    endfunction

endpackage

// File: rtl/index_decoder_onehot_decode.sv
// Combinational binary-to-one-hot decoder; an index at or beyond WIDTH
// decodes to all zeros so callers can treat it as "no lane".
module onehot_decode
    import index_pkg::*;
#(
    parameter int WIDTH = 4,
    parameter int IDXW  = idx_width(WIDTH)
) (
    input  logic [IDXW-1:0]  idx,
    output logic [WIDTH-1:0] onehot
);

    always_comb begin
        onehot = '0;
        for (int i = 0; i < WIDTH; i++) begin
            onehot[i] = (IDXW'(i) == idx);
        end
    end

endmodule

// File: rtl/index_decoder.sv
// Pending-slot tracker: binary set/clear requests update a pending vector,
// with one-hot echo of accepted sets, occupancy count and full/empty flags.
// Optional sticky err output is enabled by defining INDEX_DECODER_ERR_EN.
//
// Handshake: a set transfers on a rising edge where set_valid && set_ready;
// set_ready depends only on set_idx and registered state. Clears have no
// ready and are always accepted.
module index_decoder
    import index_pkg::*;
#(
    parameter int WIDTH = 4,
    localparam int IDXW = idx_width(WIDTH),
    localparam int CNTW = cnt_width(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             set_valid,
    input  logic [IDXW-1:0]  set_idx,
    output logic             set_ready,
    input  logic             clr_valid,
    input  logic [IDXW-1:0]  clr_idx,
    output logic [WIDTH-1:0] pend,
    output logic [WIDTH-1:0] onehot,
    output logic             onehot_valid,
    output logic [CNTW-1:0]  count,
    output logic             full,
`ifdef INDEX_DECODER_ERR_EN
    output logic             err,
`endif
    output logic             empty
);

    logic [WIDTH-1:0] set_mask;
    logic [WIDTH-1:0] clr_mask;
    logic [WIDTH-1:0] pend_next;
    logic [CNTW-1:0]  count_next;
    logic             set_acc;
    logic             clr_hit;

    onehot_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_set_dec (
        .idx    (set_idx),
        .onehot (set_mask)
    );

    onehot_decode #(.WIDTH(WIDTH), .IDXW(IDXW)) u_clr_dec (
        .idx    (clr_idx),
        .onehot (clr_mask)
    );

    // An empty mask means out of range; that and an already-pending slot stall.
    assign set_ready = (|set_mask) && !(|(set_mask & pend));

    always_comb begin
        set_acc    = set_valid && set_ready;
        clr_hit    = clr_valid && (|(clr_mask & pend));
        pend_next  = pend;
        count_next = count;
        // Clear first, then set, so a same-index set/clear leaves the slot pending.
        if (clr_valid) begin
            pend_next = pend_next & ~clr_mask;
        end
        if (set_acc) begin
            pend_next = pend_next | set_mask;
        end
        if (set_acc && !clr_hit) begin
            count_next = count + CNTW'(1);
        end else if (!set_acc && clr_hit) begin
            count_next = count - CNTW'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            pend         <= '0;
            onehot       <= '0;
            onehot_valid <= 1'b0;
            count        <= '0;
            full         <= 1'b0;
            empty        <= 1'b1;
        end else begin
            pend         <= pend_next;
            onehot       <= set_acc ? set_mask : '0;
            onehot_valid <= set_acc;
            count        <= count_next;
            full         <= (count_next == CNTW'(WIDTH));
            empty        <= (count_next == '0);
        end
    end

`ifdef INDEX_DECODER_ERR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            err <= 1'b0;
        end else if ((set_valid && !(|set_mask)) ||
                     (clr_valid && !(|(clr_mask & pend)))) begin
            err <= 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_index_decoder.sv
// Directed bench for index_decoder (WIDTH=4): a driver pushes expected
// state/one-hot records into queues, a negedge monitor pops and compares.
module tb_index_decoder;

    logic       clk;
    logic       rst;
    logic       set_valid;
    logic [1:0] set_idx;
    logic       set_ready;
    logic       clr_valid;
    logic [1:0] clr_idx;
    logic [3:0] pend;
    logic [3:0] onehot;
    logic       onehot_valid;
    logic [2:0] count;
    logic       full;
    logic       empty;
`ifdef INDEX_DECODER_ERR_EN
    logic       err;
`endif

    int total = 0;
    int bad   = 0;

    // {onehot_valid, full, empty, count[2:0], pend[3:0]}
    logic [9:0] exp_q[$];
    logic [3:0] oh_q[$];

    index_decoder #(.WIDTH(4)) dut (
        .clk          (clk),
        .rst          (rst),
        .set_valid    (set_valid),
        .set_idx      (set_idx),
        .set_ready    (set_ready),
        .clr_valid    (clr_valid),
        .clr_idx      (clr_idx),
        .pend         (pend),
        .onehot       (onehot),
        .onehot_valid (onehot_valid),
        .count        (count),
        .full         (full),
`ifdef INDEX_DECODER_ERR_EN
        .err          (err),
`endif
        .empty        (empty)
    );

    // Clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Driver: apply one cycle of stimulus, check set_ready, queue the expected result.
    task automatic step(input string name, input logic sv, input logic [1:0] si,
                        input logic cv, input logic [1:0] ci, input logic exp_ready,
                        input logic [3:0] exp_pend, input logic [2:0] exp_count,
                        input logic [3:0] exp_oh);
        set_valid = sv;
        set_idx   = si;
        clr_valid = cv;
        clr_idx   = ci;
        #1;
        if (sv) chk({name, " set_ready"}, {63'd0, set_ready}, {63'd0, exp_ready});
        exp_q.push_back({exp_oh != 4'd0, exp_count == 3'd4, exp_count == 3'd0, exp_count, exp_pend});
        if (exp_oh != 4'd0) oh_q.push_back(exp_oh);
        @(posedge clk);
        @(negedge clk);
        set_valid = 1'b0;
        clr_valid = 1'b0;
    endtask

    // Scoreboard monitor
    always @(negedge clk) begin
        if (!rst) begin
            if (onehot_valid) begin
                if (oh_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL onehot_valid: got 1 expected 0 (nothing queued) at %0t", $time);
                end else begin
                    chk("onehot", {60'd0, onehot}, {60'd0, oh_q.pop_front()});
                end
            end
            if (exp_q.size() != 0) begin
                logic [9:0] e;
                e = exp_q.pop_front();
                chk("onehot_valid", {63'd0, onehot_valid}, {63'd0, e[9]});
                chk("full", {63'd0, full}, {63'd0, e[8]});
                chk("empty", {63'd0, empty}, {63'd0, e[7]});
                chk("count", {61'd0, count}, {61'd0, e[6:4]});
                chk("pend", {60'd0, pend}, {60'd0, e[3:0]});
                if (!onehot_valid) chk("onehot idle", {60'd0, onehot}, 64'd0);
            end
        end
    end

    initial begin
        rst = 1'b1;
        set_valid = 1'b0;
        set_idx = 2'd0;
        clr_valid = 1'b0;
        clr_idx = 2'd0;
        #1;
        chk("reset pend", {60'd0, pend}, 64'd0);
        chk("reset count", {61'd0, count}, 64'd0);
        chk("reset empty", {63'd0, empty}, 64'd1);
        chk("reset full", {63'd0, full}, 64'd0);
        chk("reset onehot_valid", {63'd0, onehot_valid}, 64'd0);
`ifdef INDEX_DECODER_ERR_EN
        chk("reset err", {63'd0, err}, 64'd0);
`endif
        @(negedge clk);
        rst = 1'b0;

        //    name        sv    si    cv    ci   rdy   pend     cnt   oh
        step("set2",      1, 2'd2, 0, 2'd0, 1, 4'b0100, 3'd1, 4'b0100);
        step("dup2",      1, 2'd2, 0, 2'd0, 0, 4'b0100, 3'd1, 4'b0000);
        step("clr2",      0, 2'd0, 1, 2'd2, 0, 4'b0000, 3'd0, 4'b0000);
        step("set0",      1, 2'd0, 0, 2'd0, 1, 4'b0001, 3'd1, 4'b0001);
        step("set1",      1, 2'd1, 0, 2'd0, 1, 4'b0011, 3'd2, 4'b0010);
        step("set2b",     1, 2'd2, 0, 2'd0, 1, 4'b0111, 3'd3, 4'b0100);
        step("set3",      1, 2'd3, 0, 2'd0, 1, 4'b1111, 3'd4, 4'b1000);
        for (int i = 0; i < 4; i++) begin
            step("full_set", 1, 2'(i), 0, 2'd0, 0, 4'b1111, 3'd4, 4'b0000);
        end
        step("clr0",      0, 2'd0, 1, 2'd0, 0, 4'b1110, 3'd3, 4'b0000);
        step("clr2b",     0, 2'd0, 1, 2'd2, 0, 4'b1010, 3'd2, 4'b0000);
        step("set0_clr3", 1, 2'd0, 1, 2'd3, 1, 4'b0011, 3'd2, 4'b0001);
        step("clr0b",     0, 2'd0, 1, 2'd0, 0, 4'b0010, 3'd1, 4'b0000);
        step("clr1",      0, 2'd0, 1, 2'd1, 0, 4'b0000, 3'd0, 4'b0000);
`ifdef INDEX_DECODER_ERR_EN
        chk("err clean", {63'd0, err}, 64'd0);
`endif
        step("set1_clr1", 1, 2'd1, 1, 2'd1, 1, 4'b0010, 3'd1, 4'b0010);
`ifdef INDEX_DECODER_ERR_EN
        chk("err same-idx clr", {63'd0, err}, 64'd1);
`endif
        step("clr1b",     0, 2'd0, 1, 2'd1, 0, 4'b0000, 3'd0, 4'b0000);
        step("clr3_idle", 0, 2'd0, 1, 2'd3, 0, 4'b0000, 3'd0, 4'b0000);
`ifdef INDEX_DECODER_ERR_EN
        chk("err sticky", {63'd0, err}, 64'd1);
`endif
        step("set1b",     1, 2'd1, 0, 2'd0, 1, 4'b0010, 3'd1, 4'b0010);
        step("set2c",     1, 2'd2, 0, 2'd0, 1, 4'b0110, 3'd2, 4'b0100);

        // Asynchronous reset between edges, with a set held through the edge.
        #2;
        rst = 1'b1;
        #1;
        chk("async pend", {60'd0, pend}, 64'd0);
        chk("async count", {61'd0, count}, 64'd0);
        chk("async empty", {63'd0, empty}, 64'd1);
        chk("async full", {63'd0, full}, 64'd0);
        set_valid = 1'b1;
        set_idx = 2'd3;
        @(posedge clk);
        @(negedge clk);
        #1;
        rst = 1'b0;
        set_valid = 1'b0;
        #1;
        chk("post-reset pend", {60'd0, pend}, 64'd0);
        chk("post-reset onehot_valid", {63'd0, onehot_valid}, 64'd0);
`ifdef INDEX_DECODER_ERR_EN
        chk("post-reset err", {63'd0, err}, 64'd0);
`endif
        step("set3b",     1, 2'd3, 0, 2'd0, 1, 4'b1000, 3'd1, 4'b1000);

        repeat (2) @(negedge clk);
        #1;
        chk("exp_q drained", 64'(exp_q.size()), 64'd0);
        chk("oh_q drained", 64'(oh_q.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
